// File: rtl/p2s_rr_scheduler_if.sv
// Requester-side bundle for the shared serial lane: per-channel words and requests
// in, capture acknowledges and the framed serial stream out.
interface p2s_rr_scheduler_if #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 4,
  parameter int CH_W   = $clog2(NUM_CH)
);
  logic                     enable;
  logic [NUM_CH-1:0]        req;
  logic [NUM_CH*DATA_W-1:0] din;
  logic [NUM_CH-1:0]        ack;
  logic                     dout;
  logic                     dout_valid;
  logic                     sof;
  logic                     eof;
  logic [CH_W-1:0]          cur_ch;
  logic                     busy;

  // Producer / link side
  modport master (
    output enable, req, din,
    input  ack, dout, dout_valid, sof, eof, cur_ch, busy
  );

  // Scheduler side
  modport slave (
    input  enable, req, din,
    output ack, dout, dout_valid, sof, eof, cur_ch, busy
  );
endinterface

// File: rtl/p2s_rr_scheduler.sv
// Round-robin shared MSB-first serializer: grants one requester per frame, captures
// its word, then shifts it out with sof/eof strobes; frames chain with no idle gap.
module p2s_rr_scheduler #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 4,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  p2s_rr_scheduler_if.slave bus
);
  localparam int              CNT_W      = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(DATA_W - 1);
  localparam logic [CH_W:0]   NUM_CH_EXT = (CH_W + 1)'(NUM_CH);
  localparam logic [CH_W-1:0] LAST_CH    = CH_W'(NUM_CH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            state_reg;
  logic [DATA_W-1:0] shreg_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [NUM_CH-1:0] ack_reg;
  logic [CH_W-1:0]   cur_ch_reg;
  logic [CH_W-1:0]   last_grant_reg;

  logic [DATA_W-1:0] word [NUM_CH];
  logic [NUM_CH-1:0] grant_onehot;
  logic [CH_W-1:0]   grant_idx;
  logic [CH_W:0]     probe;
  logic              shifting;
  logic              frame_done;
  logic              grant_take;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign word[gi]         = bus.din[gi*DATA_W +: DATA_W];
      assign grant_onehot[gi] = (grant_idx == CH_W'(gi));
    end
  endgenerate

  // Walk offsets from farthest to nearest so the nearest requester after
  // last_grant is the one left standing.
  always_comb begin
    grant_idx = '0;
    probe     = '0;
    for (int k = NUM_CH; k >= 1; k--) begin
      probe = {1'b0, last_grant_reg} + (CH_W + 1)'(k);
      if (probe >= NUM_CH_EXT) begin
        probe = probe - NUM_CH_EXT;
      end
      if (bus.req[probe[CH_W-1:0]]) begin
        grant_idx = probe[CH_W-1:0];
      end
    end
  end

  assign shifting   = (state_reg == SHIFT);
  assign frame_done = !shifting || (cnt_reg == LAST_CNT);
  assign grant_take = bus.enable && (|bus.req) && frame_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      shreg_reg      <= '0;
      cnt_reg        <= '0;
      ack_reg        <= '0;
      cur_ch_reg     <= '0;
      last_grant_reg <= LAST_CH;
    end else begin
      ack_reg <= '0;
      if (grant_take) begin
        state_reg      <= SHIFT;
        shreg_reg      <= word[grant_idx];
        cnt_reg        <= '0;
        ack_reg        <= grant_onehot;
        cur_ch_reg     <= grant_idx;
        last_grant_reg <= grant_idx;
      end else if (shifting && bus.enable) begin
        if (cnt_reg == LAST_CNT) begin
          state_reg <= IDLE;
          shreg_reg <= '0;
          cnt_reg   <= '0;
        end else begin
          shreg_reg <= shreg_reg << 1;
          cnt_reg   <= cnt_reg + CNT_W'(1);
        end
      end
    end
  end

  assign bus.ack        = ack_reg;
  assign bus.dout       = shifting & shreg_reg[DATA_W-1];
  assign bus.dout_valid = shifting & bus.enable;
  assign bus.sof        = shifting & bus.enable & (cnt_reg == '0);
  assign bus.eof        = shifting & bus.enable & (cnt_reg == LAST_CNT);
  assign bus.cur_ch     = cur_ch_reg;
  assign bus.busy       = shifting;

  a_ack_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(ack_reg));
  a_ack_in_shift: assert property (@(posedge clk) disable iff (!rst_n)
    (|ack_reg) |-> (state_reg == SHIFT));
  a_idle_clear: assert property (@(posedge clk) disable iff (!rst_n)
    (state_reg == IDLE) |-> (shreg_reg == '0));
endmodule

// File: tb/tb_p2s_rr_scheduler.sv
// Bench for p2s_rr_scheduler: directed scenarios plus random traffic, every cycle
// compared against a queue-based model of the lane and round-robin grant order.
module tb_p2s_rr_scheduler;
  localparam int NUM_CH = 4;
  localparam int DATA_W = 4;
  localparam int CH_W   = $clog2(NUM_CH);

  logic clk;
  logic rst_n;

  p2s_rr_scheduler_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) bus ();

  p2s_rr_scheduler #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Lane model: remaining bits of the frame on the wire, MSB first.
  bit m_bits[$];
  int m_ch, m_last, m_ack, m_ack_prev;

  // Requester agents
  bit [NUM_CH-1:0] sticky;
  int req_pct;

  // Observed-stream capture for directed checks
  logic [31:0] obs_grants, obs_bits;
  int obs_ngrants, obs_nbits, obs_sof, obs_eof, obs_stall;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [NUM_CH-1:0] r, input int last);
    for (int k = 1; k <= NUM_CH; k++) begin
      if (r[(last + k) % NUM_CH]) return (last + k) % NUM_CH;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_bits.delete();
    m_ch       = 0;
    m_last     = NUM_CH - 1;
    m_ack      = -1;
    m_ack_prev = -1;
  endtask

  task automatic model_edge();
    int g;
    logic [DATA_W-1:0] w;
    m_ack_prev = m_ack;
    m_ack      = -1;
    if (bus.enable) begin
      if (m_bits.size() > 1) begin
        void'(m_bits.pop_front());
      end else begin
        g = rr_pick(bus.req, m_last);
        if (g >= 0) begin
          w = bus.din[g*DATA_W +: DATA_W];
          m_bits.delete();
          for (int b = DATA_W - 1; b >= 0; b--) m_bits.push_back(w[b]);
          m_ch   = g;
          m_last = g;
          m_ack  = g;
          $display("grant ch%0d word %h at %0t", g, w, $time);
        end else if (m_bits.size() == 1) begin
          void'(m_bits.pop_front());
        end
      end
    end
  endtask

  task automatic check_outputs();
    bit busy_e, valid_e, dout_e;
    busy_e  = (m_bits.size() > 0);
    valid_e = busy_e && bus.enable;
    dout_e  = busy_e ? m_bits[0] : 1'b0;
    check("ack", 32'(bus.ack), (m_ack >= 0) ? (32'd1 << m_ack) : 32'd0);
    check("busy", 32'(bus.busy), 32'(busy_e));
    check("dout_valid", 32'(bus.dout_valid), 32'(valid_e));
    check("dout", 32'(bus.dout), 32'(dout_e));
    check("sof", 32'(bus.sof), 32'(valid_e && m_bits.size() == DATA_W));
    check("eof", 32'(bus.eof), 32'(valid_e && m_bits.size() == 1));
    check("cur_ch", 32'(bus.cur_ch), 32'(m_ch));
  endtask

  task automatic capture();
    if (bus.ack != '0) begin
      obs_ngrants++;
      for (int i = 0; i < NUM_CH; i++) begin
        if (bus.ack[i]) obs_grants = {obs_grants[27:0], 4'(i)};
      end
    end
    if (bus.dout_valid) begin
      obs_nbits++;
      obs_bits = {obs_bits[30:0], bus.dout};
    end
    if (bus.sof) obs_sof++;
    if (bus.eof) obs_eof++;
    if (bus.busy && !bus.dout_valid) obs_stall++;
  endtask

  task automatic clear_obs();
    obs_grants = '0; obs_bits = '0;
    obs_ngrants = 0; obs_nbits = 0; obs_sof = 0; obs_eof = 0; obs_stall = 0;
  endtask

  task automatic update_agents();
    for (int i = 0; i < NUM_CH; i++) begin
      if (m_ack_prev == i) begin
        if (!sticky[i]) bus.req[i] = 1'b0;
      end else if (!bus.req[i] && $urandom_range(99) < req_pct) begin
        bus.req[i] = 1'b1;
        bus.din[i*DATA_W +: DATA_W] = DATA_W'($urandom);
      end
    end
  endtask

  task automatic cycle(input bit en);
    @(posedge clk);
    model_edge();
    #1;
    update_agents();
    bus.enable = en;
    @(negedge clk);
    check_outputs();
    capture();
  endtask

  task automatic apply_reset();
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1);
  endtask

  initial begin
    rst_n = 1'b1;
    bus.enable = 1'b0;
    bus.req = '0;
    bus.din = '0;
    sticky = '0;
    req_pct = 0;
    model_reset();
    #2;
    apply_reset();

    // Single ch2 frame 1011
    bus.req = 4'b0100; bus.din = 16'h0B00; bus.enable = 1'b1;
    clear_obs();
    for (int i = 0; i < 6; i++) cycle(1'b1);
    check("t1_ngrants", obs_ngrants, 1);
    check("t1_grants", obs_grants, 32'h2);
    check("t1_nbits", obs_nbits, 4);
    check("t1_bits", obs_bits, 32'hB);
    check("t1_sof", obs_sof, 1);
    check("t1_eof", obs_eof, 1);

    // All four channels at once from reset priority
    apply_reset();
    bus.req = 4'hF; bus.din = 16'hC35A; bus.enable = 1'b1;
    clear_obs();
    for (int i = 0; i < 17; i++) cycle(1'b1);
    check("t2_grants", obs_grants, 32'h0123);
    check("t2_nbits", obs_nbits, 16);
    check("t2_bits", obs_bits, 32'hA53C);
    check("t2_sof", obs_sof, 4);
    check("t2_eof", obs_eof, 4);

    // ch1 and ch3 requesting continuously alternate
    sticky = 4'b1010; bus.req = 4'b1010; bus.din = 16'h9060;
    clear_obs();
    for (int i = 0; i < 16; i++) cycle(1'b1);
    check("t3_grants", obs_grants, 32'h1313);
    check("t3_bits", obs_bits, 32'h6969);
    sticky = '0; bus.req = '0;
    drain(4);

    // Stall for three cycles after the second bit
    bus.req = 4'b0001; bus.din = 16'h000C;
    clear_obs();
    cycle(1'b1); cycle(1'b1);
    cycle(1'b0); cycle(1'b0); cycle(1'b0);
    cycle(1'b1); cycle(1'b1); cycle(1'b1);
    check("t4_nbits", obs_nbits, 4);
    check("t4_bits", obs_bits, 32'hC);
    check("t4_stall", obs_stall, 3);
    check("t4_eof", obs_eof, 1);
    drain(2);

    // Request ignored while idle and disabled
    bus.enable = 1'b0; bus.req = 4'b0001; bus.din = 16'h0005;
    clear_obs();
    for (int i = 0; i < 5; i++) cycle(1'b0);
    cycle(1'b1);
    check("t6_ngrants", obs_ngrants, 0);
    check("t6_nbits", obs_nbits, 0);
    cycle(1'b1);
    check("t6_ack", 32'(bus.ack), 32'h1);
    check("t6_sof", 32'(bus.sof), 32'h1);
    drain(5);

    // Reset in the middle of a ch1 frame with req still held
    sticky = 4'b0010; bus.req = 4'b0010; bus.din = 16'h0090;
    cycle(1'b1);
    check("t5_first_bit", 32'(bus.dout), 32'h1);
    apply_reset();
    check("t5_rst_busy", 32'(bus.busy), 32'h0);
    check("t5_rst_valid", 32'(bus.dout_valid), 32'h0);
    clear_obs();
    for (int i = 0; i < 4; i++) cycle(1'b1);
    check("t5_grants", obs_grants, 32'h1);
    check("t5_nbits", obs_nbits, 4);
    check("t5_bits", obs_bits, 32'h9);
    sticky = '0; bus.req = '0;
    drain(3);

    // Random traffic with stalls and occasional resets
    req_pct = 30;
    for (int n = 0; n < 3000; n++) begin
      cycle($urandom_range(99) < 80);
      if ($urandom_range(199) == 0) apply_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
